cnn_gated: RTL and testbench

// - Self-contained, free-running binary CNN pattern detector with fine-grain operand gating.
// - Slides a fixed 3x3 kernel over an 8x8 on-chip binary image using one MAC per cycle.
// - Counts the windows whose score reaches a threshold and reports the count.
// - Top-level demo block: it has no data inputs; image and kernel are build-time constants.

---
 rtl/cnn_gated_pkg.sv | 36 +++
 rtl/cnn_mac_gated.sv | 32 +++
 rtl/cnn_gated.sv | 105 ++++++++++
 tb/tb_cnn_gated.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_gated_pkg.sv
// Shared constants, state type and pixel addressing for the gated binary CNN detector.
package cnn_gated_pkg;

    localparam int unsigned IMG_W = 8;
    localparam int unsigned IMG_H = 8;
    localparam int unsigned KSZ   = 3;
    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned NTAP  = KSZ * KSZ;
    localparam int unsigned NWIN  = (IMG_H - KSZ + 1) * (IMG_W - KSZ + 1);

    localparam int unsigned ACC_W  = 5;
    localparam int unsigned POS_W  = $clog2(IMG_H - KSZ + 1);
    localparam int unsigned TAP_W  = $clog2(NTAP);
    localparam int unsigned IDX_W  = $clog2(NPIX);

    localparam int unsigned     DEF_CNT_W  = 4;
    localparam logic [NPIX-1:0] DEF_IMAGE  = 64'h44EE440010381000;
    localparam logic [NTAP-1:0] DEF_KERNEL = 9'b010111010;
    localparam int              DEF_THRESH = 5;

    typedef enum logic [1:0] {SCAN, CMP, DONE} state_t;

    // Image bit 63 is (row0,col0), so the linear pixel number is mirrored.
    function automatic logic [IDX_W-1:0] pix_index(input logic [POS_W-1:0] row,
                                                   input logic [POS_W-1:0] col,
                                                   input logic [TAP_W-1:0] tap);
        int unsigned t;
        int unsigned r;
        int unsigned c;
        t = 32'(tap);
        r = 32'(row) + t / KSZ;
        c = 32'(col) + t % KSZ;
        return IDX_W'(NPIX - 1 - (r * IMG_W + c));
    endfunction

endpackage

// File: rtl/cnn_mac_gated.sv
// Single-tap +/-1 accumulator; the register only updates for a set pixel, so zero pixels
// cost no toggles in the MAC path.
module cnn_mac_gated
    import cnn_gated_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    pixel,
    input  logic                    weight_bit,
    output logic signed [ACC_W-1:0] acc
);

    logic                    acc_en;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] operand;

    assign acc_en  = en & pixel;
    assign operand = weight_bit ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_q <= '0;
        end else if (acc_en) begin
            acc_q <= acc_q + operand;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/cnn_gated.sv
// Free-running 3x3 binary pattern detector over a constant 8x8 image; one tap per cycle,
// one compare cycle per window, saturating match count.
module cnn_gated
    import cnn_gated_pkg::*;
#(
    parameter logic [NPIX-1:0] IMAGE  = DEF_IMAGE,
    parameter logic [NTAP-1:0] KERNEL = DEF_KERNEL,
    parameter int              THRESH = DEF_THRESH,
    parameter int unsigned     CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] numberOfTimes_PatterDetected
);

    localparam logic [POS_W-1:0]        LAST_ROW = POS_W'(IMG_H - KSZ);
    localparam logic [POS_W-1:0]        LAST_COL = POS_W'(IMG_W - KSZ);
    localparam logic [TAP_W-1:0]        LAST_TAP = TAP_W'(NTAP - 1);
    localparam logic signed [ACC_W-1:0] THR      = ACC_W'(THRESH);

    state_t                  state_q, state_d;
    logic [POS_W-1:0]        row_q, row_d;
    logic [POS_W-1:0]        col_q, col_d;
    logic [TAP_W-1:0]        tap_q, tap_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    mac_en;
    logic                    mac_clr;
    logic                    pixel;
    logic                    weight_bit;
    logic signed [ACC_W-1:0] acc;

    assign pixel      = IMAGE[pix_index(row_q, col_q, tap_q)];
    // Kernel is MSB-first, so tap 0 reads the top bit.
    assign weight_bit = KERNEL[LAST_TAP - tap_q];

    cnn_mac_gated u_mac (
        .clk        (clk),
        .rst        (rst),
        .clr        (mac_clr),
        .en         (mac_en),
        .pixel      (pixel),
        .weight_bit (weight_bit),
        .acc        (acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCAN;
            row_q   <= '0;
            col_q   <= '0;
            tap_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            tap_q   <= tap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        tap_d   = tap_q;
        cnt_d   = cnt_q;
        mac_en  = 1'b0;
        mac_clr = 1'b0;
        unique case (state_q)
            SCAN: begin
                mac_en = 1'b1;
                if (tap_q == LAST_TAP) begin
                    tap_d   = '0;
                    state_d = CMP;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            CMP: begin
                mac_clr = 1'b1;
                if (acc == THR && cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (row_q == LAST_ROW && col_q == LAST_COL) begin
                    state_d = DONE;
                end else begin
                    state_d = SCAN;
                    if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DONE: begin
            end
            default: state_d = SCAN;
        endcase
    end

    assign numberOfTimes_PatterDetected = cnt_q;

endmodule

// File: tb/tb_cnn_gated.sv
// Directed bench: four detector builds (default, blank, all-ones saturating, single plus)
// share one clock and reset.
module tb_cnn_gated;
    import cnn_gated_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cnt_def;
    logic [3:0] cnt_zero;
    logic [3:0] cnt_sat;
    logic [3:0] cnt_plus;

    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    int unsigned zero_en_cnt = 0;
    int unsigned en_base = 0;

    always #5 clk = ~clk;

    cnn_gated u_def (
        .clk                          (clk),
        .rst                          (rst),
        .numberOfTimes_PatterDetected (cnt_def)
    );

    cnn_gated #(
        .IMAGE (64'h0)
    ) u_zero (
        .clk                          (clk),
        .rst                          (rst),
        .numberOfTimes_PatterDetected (cnt_zero)
    );

    cnn_gated #(
        .IMAGE  (64'hFFFF_FFFF_FFFF_FFFF),
        .KERNEL (9'h1FF),
        .THRESH (9)
    ) u_sat (
        .clk                          (clk),
        .rst                          (rst),
        .numberOfTimes_PatterDetected (cnt_sat)
    );

    cnn_gated #(
        .IMAGE (64'h40E0_4000_0000_0000)
    ) u_plus (
        .clk                          (clk),
        .rst                          (rst),
        .numberOfTimes_PatterDetected (cnt_plus)
    );

    always @(posedge clk) begin
        if (u_zero.u_mac.acc_en) zero_en_cnt <= zero_en_cnt + 1;
    end

    // Sample 1 time unit after the edge, well away from the next one.
    task automatic advance_to(input int target);
        while (edge_n < target) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (cnt_def !== 4'd0 || cnt_sat !== 4'd0) begin
                errors++;
                $display("FAIL reset_count cycle %0d: def=%0d sat=%0d, required 0", i, cnt_def,
                         cnt_sat);
            end
            checks++;
            if (u_def.state_q !== SCAN || u_def.row_q !== 3'd0 || u_def.col_q !== 3'd0 ||
                u_def.tap_q !== 4'd0) begin
                errors++;
                $display("FAIL reset_fsm cycle %0d: state=%0d row=%0d col=%0d tap=%0d, required 0",
                         i, u_def.state_q, u_def.row_q, u_def.col_q, u_def.tap_q);
            end
        end
        rst     = 1'b0;
        edge_n  = 0;
        en_base = zero_en_cnt;
    endtask

    task automatic test_scan();
        advance_to(9);
        checks++;
        if (cnt_plus !== 4'd0) begin
            errors++;
            $display("FAIL plus_before_cmp: got %0d, required 0", cnt_plus);
        end
        advance_to(10);
        checks++;
        if (cnt_plus !== 4'd1) begin
            errors++;
            $display("FAIL plus_at_cmp: got %0d, required 1", cnt_plus);
        end
        advance_to(49);
        checks++;
        if (cnt_def !== 4'd1) begin
            errors++;
            $display("FAIL def_edge49: got %0d, required 1", cnt_def);
        end
        advance_to(50);
        checks++;
        if (cnt_def !== 4'd2) begin
            errors++;
            $display("FAIL def_edge50: got %0d, required 2", cnt_def);
        end
        advance_to(149);
        checks++;
        if (cnt_sat !== 4'd14) begin
            errors++;
            $display("FAIL sat_edge149: got %0d, required 14", cnt_sat);
        end
        advance_to(150);
        checks++;
        if (cnt_sat !== 4'd15) begin
            errors++;
            $display("FAIL sat_edge150: got %0d, required 15", cnt_sat);
        end
        advance_to(269);
        checks++;
        if (cnt_def !== 4'd2) begin
            errors++;
            $display("FAIL def_edge269: got %0d, required 2", cnt_def);
        end
        advance_to(270);
        checks++;
        if (cnt_def !== 4'd3) begin
            errors++;
            $display("FAIL def_edge270: got %0d, required 3", cnt_def);
        end
        advance_to(359);
        checks++;
        if (u_def.state_q !== CMP) begin
            errors++;
            $display("FAIL state_edge359: got %0d, required CMP", u_def.state_q);
        end
        advance_to(360);
        checks++;
        if (u_def.state_q !== DONE) begin
            errors++;
            $display("FAIL state_edge360: got %0d, required DONE", u_def.state_q);
        end
        checks++;
        if (cnt_def !== 4'd3 || cnt_zero !== 4'd0 || cnt_sat !== 4'd15 || cnt_plus !== 4'd1) begin
            errors++;
            $display("FAIL final_counts: def=%0d zero=%0d sat=%0d plus=%0d, required 3 0 15 1",
                     cnt_def, cnt_zero, cnt_sat, cnt_plus);
        end
        checks++;
        if (zero_en_cnt != en_base) begin
            errors++;
            $display("FAIL zero_acc_en: got %0d enabled cycles, required 0",
                     zero_en_cnt - en_base);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            advance_to(edge_n + 100);
            checks++;
            if (cnt_def !== 4'd3 || cnt_sat !== 4'd15 || cnt_plus !== 4'd1 ||
                u_def.state_q !== DONE) begin
                errors++;
                $display("FAIL hold_done step %0d: def=%0d sat=%0d plus=%0d state=%0d", i,
                         cnt_def, cnt_sat, cnt_plus, u_def.state_q);
            end
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        advance_to(edge_n + 1);
        rst    = 1'b0;
        edge_n = 0;
        advance_to(200);
        checks++;
        if (cnt_def !== 4'd2) begin
            errors++;
            $display("FAIL mid_before_rst: got %0d, required 2", cnt_def);
        end
        rst = 1'b1;
        advance_to(201);
        checks++;
        if (cnt_def !== 4'd0 || u_def.state_q !== SCAN || u_def.tap_q !== 4'd0 ||
            u_def.row_q !== 3'd0 || u_def.col_q !== 3'd0) begin
            errors++;
            $display("FAIL mid_rst: cnt=%0d state=%0d tap=%0d row=%0d col=%0d, required all 0",
                     cnt_def, u_def.state_q, u_def.tap_q, u_def.row_q, u_def.col_q);
        end
        rst    = 1'b0;
        edge_n = 0;
        advance_to(360);
        checks++;
        if (cnt_def !== 4'd3 || u_def.state_q !== DONE) begin
            errors++;
            $display("FAIL mid_rescan: cnt=%0d state=%0d, required 3 DONE", cnt_def,
                     u_def.state_q);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_hold();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
